// File: rtl/mouse_cfg_arbiter.sv
// mouse_cfg_arbiter
//   Shares the MouseCtl configuration port among three requesters
//   (0 boundary constrainer, 1 game-logic cursor, 2 debug/test).
//   Round-robin grant, one strobe per granted write, GAP_CYCLES idle
//   cycles after each strobe.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   req[2:0]           level request per requester
//   cmd[8:0]           3-bit command per requester, cmd[3i+2:3i]
//   data[35:0]         12-bit data per requester, data[12i+11:12i]
//   ack[2:0]           one-cycle accept pulse
//   busy               high while not IDLE
//   err                one-cycle pulse on an accepted illegal command
//   value[11:0]        write data to MouseCtl
//   set_x .. setmin_y  one-hot MouseCtl write strobes
// Build option:
//   MOUSE_CFG_CLAMP_EN  keep shadow min/max registers and clamp SET_X/SET_Y.
module mouse_cfg_arbiter #(
  parameter int GAP_CYCLES = 1,
  parameter int RST_MAX_X  = 1019,
  parameter int RST_MAX_Y  = 763
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [8:0]  cmd,
  input  logic [35:0] data,
  output logic [2:0]  ack,
  output logic        busy,
  output logic        err,
  output logic [11:0] value,
  output logic        set_x,
  output logic        set_y,
  output logic        setmax_x,
  output logic        setmax_y,
  output logic        setmin_x,
  output logic        setmin_y
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  gap_cnt;
  logic [1:0]  rr;
  logic [5:0]  strb;

  logic        grant;
  logic [1:0]  win;
  logic [2:0]  pos;
  logic [2:0]  win_cmd;
  logic [11:0] win_data;
  logic        illegal;
  logic [5:0]  strb_nxt;
  logic [11:0] val_nxt;

`ifdef MOUSE_CFG_CLAMP_EN
  logic [11:0] min_x, min_y, max_x, max_y;

  // An inverted window (lo > hi) always yields lo.
  function automatic logic [11:0] clamp(input logic [11:0] d, lo, hi);
    if (lo > hi)     return lo;
    else if (d < lo) return lo;
    else if (d > hi) return hi;
    else             return d;
  endfunction
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = HOLD;
      HOLD:    state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt <= 3'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant decode: first requester found scanning from rr upward (mod 3)
  always_comb begin
    grant = 1'b0;
    win   = rr;
    pos   = 3'd0;
    for (int k = 0; k < 3; k++) begin
      pos = {1'b0, rr} + 3'(k);
      if (pos >= 3'd3) pos = pos - 3'd3;
      if (!grant && req[pos[1:0]]) begin
        grant = 1'b1;
        win   = pos[1:0];
      end
    end
    win_cmd  = cmd[3*win +: 3];
    win_data = data[12*win +: 12];
    illegal  = (win_cmd > 3'd5);
    strb_nxt = '0;
    if (grant && !illegal) strb_nxt[win_cmd] = 1'b1;
    val_nxt  = win_data;
`ifdef MOUSE_CFG_CLAMP_EN
    if (win_cmd == 3'd0) val_nxt = clamp(win_data, min_x, max_x);
    if (win_cmd == 3'd1) val_nxt = clamp(win_data, min_y, max_y);
`endif
  end

  // Registered outputs, rr and gap counter; every pulse defaults low so
  // strobes/acks are exactly one cycle and die on the cycle after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack     <= '0;
      strb    <= '0;
      err     <= 1'b0;
      value   <= '0;
      rr      <= '0;
      gap_cnt <= '0;
    end else begin
      ack  <= '0;
      strb <= '0;
      err  <= 1'b0;
      if (state == IDLE && grant) begin
        ack  <= 3'b001 << win;
        rr   <= (win == 2'd2) ? 2'd0 : win + 2'd1;
        strb <= strb_nxt;
        if (illegal) err   <= 1'b1;
        else         value <= val_nxt;
      end
      if (state == HOLD)                    gap_cnt <= 3'(GAP_CYCLES);
      else if (state == GAP && gap_cnt != 0) gap_cnt <= gap_cnt - 3'd1;
    end
  end

`ifdef MOUSE_CFG_CLAMP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_x <= '0;
      min_y <= '0;
      max_x <= 12'(RST_MAX_X);
      max_y <= 12'(RST_MAX_Y);
    end else if (state == IDLE && grant) begin
      case (win_cmd)
        3'd2:    max_x <= win_data;
        3'd3:    max_y <= win_data;
        3'd4:    min_x <= win_data;
        3'd5:    min_y <= win_data;
        default: ;
      endcase
    end
  end
`endif

  assign busy = (state != IDLE);
  assign {setmin_y, setmin_x, setmax_y, setmax_x, set_y, set_x} = strb;

endmodule

// File: tb/tb_mouse_cfg_arbiter.sv
// Directed bench for mouse_cfg_arbiter (GAP_CYCLES=1).
// Strobe vector order: {setmin_y,setmin_x,setmax_y,setmax_x,set_y,set_x}.
module tb_mouse_cfg_arbiter;
  localparam int GAP = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [8:0]  cmd;
  logic [35:0] data;
  logic [2:0]  ack;
  logic        busy, err;
  logic [11:0] value;
  logic        set_x, set_y, setmax_x, setmax_y, setmin_x, setmin_y;
  logic [5:0]  stb;

  int n_run  = 0;
  int n_fail = 0;

  mouse_cfg_arbiter #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .data(data),
    .ack(ack), .busy(busy), .err(err), .value(value),
    .set_x(set_x), .set_y(set_y), .setmax_x(setmax_x), .setmax_y(setmax_y),
    .setmin_x(setmin_x), .setmin_y(setmin_y)
  );

  always #5 clk = ~clk;
  assign stb = {setmin_y, setmin_x, setmax_y, setmax_x, set_y, set_x};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge, sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [2:0] c, input logic [11:0] d);
    req[i]          = 1'b1;
    cmd[3*i +: 3]   = c;
    data[12*i +: 12] = d;
  endtask

  // single write from requester i, checks value afterwards, returns to IDLE
  task automatic post(input int i, input logic [2:0] c, input logic [11:0] d,
                      input logic [11:0] exp_val, input string tag);
    set_req(i, c, d);
    tick();
    chk({tag, "_ack"}, 32'(ack), 32'(3'b001 << i));
    chk({tag, "_val"}, 32'(value), 32'(exp_val));
    req = '0;
    repeat (1 + GAP) tick();
  endtask

  logic [2:0] exp_ack;
  logic [5:0] exp_stb;

  initial begin
    req = '0; cmd = '0; data = '0; rst_n = 1'b0;

    // reset state
    do_reset();
    chk("rst_value", 32'(value), 0);
    chk("rst_stb",   32'(stb),   0);
    chk("rst_ack",   32'(ack),   0);
    chk("rst_err",   32'(err),   0);
    chk("rst_busy",  32'(busy),  0);

    // single SETMAX_X write from requester 0
    set_req(0, 3'd2, 12'd661);
    tick();
    chk("w1_ack",  32'(ack),   32'b001);
    chk("w1_stb",  32'(stb),   32'b000100);
    chk("w1_val",  32'(value), 661);
    chk("w1_busy", 32'(busy),  1);
    chk("w1_err",  32'(err),   0);
    req = '0;
    tick();
    chk("w1_stb_off", 32'(stb),  0);
    chk("w1_ack_off", 32'(ack),  0);
    chk("w1_busy2",   32'(busy), 1);
    tick();
    chk("w1_idle",    32'(busy), 0);

    // all three requesting continuously after reset: 0,1,2,0 every 3 cycles
    do_reset();
    set_req(0, 3'd0, 12'd100);
    set_req(1, 3'd1, 12'd200);
    set_req(2, 3'd3, 12'd300);
    for (int c = 0; c < 10; c++) begin
      tick();
      exp_ack = 3'b000;
      exp_stb = 6'b000000;
      if (c % 3 == 0) begin
        case ((c / 3) % 3)
          0: begin exp_ack = 3'b001; exp_stb = 6'b000001; end
          1: begin exp_ack = 3'b010; exp_stb = 6'b000010; end
          default: begin exp_ack = 3'b100; exp_stb = 6'b001000; end
        endcase
      end
      chk($sformatf("rr_ack_c%0d", c), 32'(ack), 32'(exp_ack));
      chk($sformatf("rr_stb_c%0d", c), 32'(stb), 32'(exp_stb));
    end
    chk("rr_val", 32'(value), 100);
    req = '0;
    repeat (1 + GAP) tick();

    // illegal command from requester 2: ack + err, no strobe, value kept
    set_req(2, 3'd7, 12'd5);
    tick();
    chk("ill_ack", 32'(ack),   32'b100);
    chk("ill_err", 32'(err),   1);
    chk("ill_stb", 32'(stb),   0);
    chk("ill_val", 32'(value), 100);
    req = '0;
    tick();
    chk("ill_err_off", 32'(err), 0);
    tick();

    // reset in cycle after grant: pulses die, rr back to 0
    set_req(0, 3'd1, 12'd42);
    tick();
    chk("rm_ack", 32'(ack), 32'b001);
    chk("rm_stb", 32'(stb), 32'b000010);
    set_req(1, 3'd0, 12'd77);
    rst_n = 1'b0;
    tick();
    chk("rm_stb0",  32'(stb),   0);
    chk("rm_ack0",  32'(ack),   0);
    chk("rm_busy0", 32'(busy),  0);
    chk("rm_val0",  32'(value), 0);
    rst_n = 1'b1;
    tick();
    chk("rm_tie_ack", 32'(ack), 32'b001);
    chk("rm_tie_val", 32'(value), 42);
    req = '0;
    repeat (1 + GAP) tick();

`ifdef MOUSE_CFG_CLAMP_EN
    do_reset();
    post(0, 3'd4, 12'd361, 12'd361, "cl_min");
    post(0, 3'd2, 12'd645, 12'd645, "cl_max");
    post(1, 3'd0, 12'd100, 12'd361, "cl_lo");
    post(1, 3'd0, 12'd900, 12'd645, "cl_hi");
    post(2, 3'd0, 12'd511, 12'd511, "cl_mid");
`else
    do_reset();
    post(0, 3'd2, 12'd645, 12'd645, "nc_max");
    post(1, 3'd0, 12'd900, 12'd900, "nc_pass");
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
